mem64_copy_engine: RTL
======================

# mem64_copy_engine

Initiator for the 16x64 memory port: copies a block of 16-bit words from one 6-bit address range to another inside the 64-word memory. It issues the memory's read strobes, captures read data, and issues the write strobes. Each word is processed in sequence: read, wait, then write. It sits between a control/host block (start/length/address registers) and the memory's rd/raddr/wr/waddr/d_in/d_out port.

## Interface
- RD_LAT, 1: memory read latency in cycles (≥1); mem_rdata is valid RD_LAT cycles after the mem_rd cycle.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- start  input  1  one-cycle request; sampled only in IDLE.
- src  input  6  first source word address; sampled with start.
- dst  input  6  first destination word address; sampled with start.
- len  input  7  word count, 0..64; sampled with start.
- abort  input  1  stops an active copy.
- busy  output  1  high from the cycle after accepted start until done.
- done  output  1  one-cycle pulse at end of copy or abort.
- aborted  output  1  valid with done; 1 = copy was aborted.
- count  output  7  words written so far; holds after done until next start.
- mem_rd  output  1  memory read strobe.
- mem_raddr  output  6  memory read address.
- mem_wr  output  1  memory write strobe.
- mem_waddr  output  6  memory write address.
- mem_wdata  output  16  memory write data (to memory d_in).
- mem_rdata  input  16  memory read data (from memory d_out).

## Operation
- States: IDLE, READ, WAIT, WRITE, FIN.
- IDLE: start=1 and len≠0 → latch src/dst/len, count←0, go to READ. start=1 and len=0 → go to FIN with aborted=0; no memory access occurs. start outside IDLE is ignored.
- READ: mem_rd=1 and mem_raddr=current source pointer for exactly one cycle. Then go to WAIT. If RD_LAT=1, WAIT lasts one cycle.
- WAIT: remain for RD_LAT cycles in total after READ. In the last WAIT cycle, register mem_rdata into the data register, then go to WRITE.
- WRITE: mem_wr=1 for exactly one cycle, with mem_waddr=current destination pointer and mem_wdata=the data register. On exit, count+1, and both pointers +1 modulo 64. If count+1=len, go to FIN; otherwise go to READ.
- FIN: done=1 for one cycle, then go to IDLE.
- Address arithmetic is 6-bit and wraps 63→0. len=64 copies the whole memory.
- Copy order is ascending. Overlapping ranges with dst inside the source window produce forward-copy semantics. Each word is read after all earlier writes, so the source pattern repeats. This is required behaviour, not an error.
- abort=1 in READ or WAIT:
  - The next state is FIN with aborted=1.
  - The in-flight word is not written.
  - count is unchanged.
- abort=1 in WRITE:
  - The write completes and count increments.
  - The next state is FIN with aborted=1.
- abort in IDLE or FIN is ignored.
- mem_rd and mem_wr are never asserted in the same cycle. Outside READ and WRITE, both are 0.
- mem_raddr, mem_waddr and mem_wdata hold their last values when strobes are low.
- Reset at any time (async, rst=0) forces IDLE with all outputs 0 and registers cleared. Any copy in progress is dropped; no write is issued after reset asserts.

## Timing
- Reset values: busy=0, done=0, aborted=0, count=0, mem_rd=0, mem_wr=0, mem_raddr=0, mem_waddr=0, mem_wdata=0.
- start accepted at edge E0. busy=1 and the first mem_rd both appear in the cycle after E0.
- Each word takes RD_LAT+2 cycles: 1 READ, RD_LAT WAIT, 1 WRITE.
- With len=L, the last mem_wr occurs L·(RD_LAT+2) cycles after the first mem_rd cycle begins, minus 1. done occurs in the next cycle. busy falls in the same cycle done rises.
- len=0: done is high in the cycle after start; busy never rises.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Copy, RD_LAT=1:
  - Stimulus: preload mem[0..3]=0x1111,0x2222,0x3333,0x4444; start with src=0, dst=40, len=4.
  - Response: mem[40..43] hold the same values. The first mem_wr is 3 cycles after start. done comes 12 cycles after the first mem_rd. count=4, aborted=0.
- Wrap-around:
  - Stimulus: src=62, dst=30, len=4.
  - Response: reads at 62, 63, 0, 1; writes at 30..33.
  - Stimulus: src=0, dst=62, len=3.
  - Response: writes at 62, 63, 0.
- len=0 and len=64:
  - Stimulus: start with len=0.
  - Response: done the next cycle, with no mem_rd/mem_wr at all.
  - Stimulus: start with len=64, src=0, dst=0.
  - Response: 64 reads and 64 writes; count=64.
- Overlap:
  - Stimulus: mem[0]=0xAAAA, mem[1]=0xBBBB; src=0, dst=1, len=3.
  - Response: mem[1..3]=0xAAAA.
- Abort:
  - Stimulus: abort during the WAIT of word 3 (len=8).
  - Response: exactly 2 writes, count=2, done=1 with aborted=1 the next cycle.
  - Stimulus: abort during WRITE.
  - Response: that write still occurs.
- Reset mid-copy and ignored start:
  - Stimulus: rst=0 mid-copy.
  - Response: outputs are 0 immediately (asynchronously), and no further strobes occur.
  - Stimulus: start while busy.
  - Response: no effect on src/dst/len or count; the run with RD_LAT=3 gives 5 cycles per word.

Source files
------------

// File: rtl/mem64_copy_engine.sv
// Block copier for the 64x16 memory port: per word READ, RD_LAT WAIT cycles, WRITE.
// Every output is a flop loaded from the next-state decode, so nothing depends combinationally on an input.
module mem64_copy_engine #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  src,
  input  logic [5:0]  dst,
  input  logic [6:0]  len,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic [6:0]  count,
  output logic        mem_rd,
  output logic [5:0]  mem_raddr,
  output logic        mem_wr,
  output logic [5:0]  mem_waddr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, FIN} state_t;

  localparam int WCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [WCW-1:0] WAIT_INIT = WCW'(RD_LAT - 1);

  state_t         state_q, state_d;
  logic [5:0]     sptr_q, sptr_d, dptr_q, dptr_d;
  logic [6:0]     len_q, len_d, count_q, count_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic           busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
  logic           rd_q, rd_d, wr_q, wr_d;
  logic [5:0]     raddr_q, raddr_d, waddr_q, waddr_d;
  logic [15:0]    wdata_q, wdata_d;

  always_comb begin
    state_d   = state_q;
    sptr_d    = sptr_q;
    dptr_d    = dptr_q;
    len_d     = len_q;
    count_d   = count_q;
    wait_d    = wait_q;
    aborted_d = aborted_q;
    wdata_d   = wdata_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          count_d   = '0;
          aborted_d = 1'b0;
          if (len != 7'd0) begin
            sptr_d  = src;
            dptr_d  = dst;
            len_d   = len;
            state_d = READ;
          end else begin
            state_d = FIN;
          end
        end
      end
      READ: begin
        if (abort) begin
          state_d   = FIN;
          aborted_d = 1'b1;
        end else begin
          state_d = WAIT;
          wait_d  = WAIT_INIT;
        end
      end
      WAIT: begin
        // an abort here drops the in-flight word before it reaches the data register
        if (abort) begin
          state_d   = FIN;
          aborted_d = 1'b1;
        end else if (wait_q == '0) begin
          state_d = WRITE;
          wdata_d = mem_rdata;
        end else begin
          wait_d = wait_q - WCW'(1);
        end
      end
      WRITE: begin
        count_d = count_q + 7'd1;
        sptr_d  = sptr_q + 6'd1;
        dptr_d  = dptr_q + 6'd1;
        if (abort || (count_d == len_q)) begin
          state_d   = FIN;
          aborted_d = abort;
        end else begin
          state_d = READ;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d == READ) || (state_d == WAIT) || (state_d == WRITE);
    done_d  = (state_d == FIN);
    rd_d    = (state_d == READ);
    wr_d    = (state_d == WRITE);
    raddr_d = rd_d ? sptr_d : raddr_q;
    waddr_d = wr_d ? dptr_d : waddr_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      sptr_q    <= '0;
      dptr_q    <= '0;
      len_q     <= '0;
      count_q   <= '0;
      wait_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      raddr_q   <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      sptr_q    <= sptr_d;
      dptr_q    <= dptr_d;
      len_q     <= len_d;
      count_q   <= count_d;
      wait_q    <= wait_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      raddr_q   <= raddr_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign count     = count_q;
  assign mem_rd    = rd_q;
  assign mem_raddr = raddr_q;
  assign mem_wr    = wr_q;
  assign mem_waddr = waddr_q;
  assign mem_wdata = wdata_q;

endmodule
